// File: rtl/vin_to_axi4s.sv
// rtl/vin_to_axi4s.sv - parallel video input to AXI4-Stream video converter
// Frame-synchronised capture FSM feeding a first-word-fall-through FIFO with overflow frame abort.
module vin_to_axi4s #(
  parameter int DATA_WIDTH     = 24,
  parameter int USER_WIDTH     = 1,
  parameter int FIFO_PTR_WIDTH = 6,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   ctl_enable,
  input  logic                   ctl_clear,
  input  logic                   in_vsync,
  input  logic                   in_hsync,
  input  logic                   in_de,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic [USER_WIDTH-1:0]  m_axi4s_tuser,
  output logic                   m_axi4s_tlast,
  output logic [DATA_WIDTH-1:0]  m_axi4s_tdata,
  output logic                   m_axi4s_tvalid,
  input  logic                   m_axi4s_tready,
  output logic                   status_busy,
  output logic                   status_overflow,
  output logic [COUNT_WIDTH-1:0] status_frame_count
);

  localparam int DEPTH = 1 << FIFO_PTR_WIDTH;
  localparam int ENTRY_WIDTH = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  state_t                  state;
  logic                    vsync_d;
  logic                    vsync_rise;
  logic                    sof_armed;
  logic                    hold_v;
  logic                    hold_sof;
  logic [DATA_WIDTH-1:0]   hold_data;

  logic [FIFO_PTR_WIDTH:0] wr_ptr;
  logic [FIFO_PTR_WIDTH:0] wr_ptr_vis;
  logic [FIFO_PTR_WIDTH:0] rd_ptr;
  logic [ENTRY_WIDTH-1:0]  mem [DEPTH];
  logic [ENTRY_WIDTH-1:0]  head;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    overflow;
  logic                    unused_inputs;

  assign unused_inputs = in_hsync;

  assign vsync_rise = in_vsync & ~vsync_d;
  assign push       = (state == S_CAPTURE) && hold_v;
  assign full       = (wr_ptr[FIFO_PTR_WIDTH] != rd_ptr[FIFO_PTR_WIDTH]) &&
                      (wr_ptr[FIFO_PTR_WIDTH-1:0] == rd_ptr[FIFO_PTR_WIDTH-1:0]);
  assign overflow   = push && full && !pop;

  // Reads compare against a one-cycle-delayed write pointer, so a fresh entry
  // becomes visible the cycle after it is written; full uses the real pointer.
  assign m_axi4s_tvalid = (wr_ptr_vis != rd_ptr);
  assign pop            = m_axi4s_tvalid && m_axi4s_tready;
  assign head           = mem[rd_ptr[FIFO_PTR_WIDTH-1:0]];

  always_comb begin
    m_axi4s_tuser    = '0;
    m_axi4s_tuser[0] = m_axi4s_tvalid & head[DATA_WIDTH+1];
    m_axi4s_tlast    = m_axi4s_tvalid & head[DATA_WIDTH];
    m_axi4s_tdata    = m_axi4s_tvalid ? head[DATA_WIDTH-1:0] : '0;
  end

  always_ff @(posedge aclk) begin
    if (push && !overflow) begin
      mem[wr_ptr[FIFO_PTR_WIDTH-1:0]] <= {hold_sof, ~in_de, hold_data};
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr     <= '0;
      wr_ptr_vis <= '0;
      rd_ptr     <= '0;
    end else begin
      if (push && !overflow) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      wr_ptr_vis <= wr_ptr;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state              <= S_IDLE;
      vsync_d            <= 1'b0;
      sof_armed          <= 1'b0;
      hold_v             <= 1'b0;
      hold_sof           <= 1'b0;
      hold_data          <= '0;
      status_busy        <= 1'b0;
      status_overflow    <= 1'b0;
      status_frame_count <= '0;
    end else begin
      vsync_d <= in_vsync;
      hold_v  <= 1'b0;

      if (overflow) begin
        status_overflow <= 1'b1;
      end else if (ctl_clear) begin
        status_overflow <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (ctl_enable) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (vsync_rise) begin
            state       <= S_CAPTURE;
            sof_armed   <= 1'b1;
            status_busy <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (overflow) begin
            state       <= S_DROP;
            status_busy <= 1'b0;
          end else begin
            if (in_de) begin
              hold_v    <= 1'b1;
              hold_data <= in_data;
              hold_sof  <= sof_armed;
              sof_armed <= 1'b0;
            end
            if (vsync_rise) begin
              status_frame_count <= status_frame_count + 1'b1;
              if (ctl_enable) begin
                sof_armed <= 1'b1;
              end else begin
                state       <= S_IDLE;
                status_busy <= 1'b0;
              end
            end
          end
        end
        S_DROP: begin
          if (vsync_rise) begin
            if (ctl_enable) begin
              state       <= S_CAPTURE;
              sof_armed   <= 1'b1;
              status_busy <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          status_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vin_to_axi4s.sv
// tb/tb_vin_to_axi4s.sv - self-checking bench for vin_to_axi4s
// Frame-level reference model with a beat scoreboard; table-driven frames, directed corners, random frames.
module tb_vin_to_axi4s;

  localparam int DW    = 24;
  localparam int DEPTH = 64;
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_CAP  = 2;
  localparam int M_DROP = 3;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          ctl_enable = 1'b0;
  logic          ctl_clear = 1'b0;
  logic          in_vsync = 1'b0;
  logic          in_hsync = 1'b0;
  logic          in_de = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [0:0]    m_axi4s_tuser;
  logic          m_axi4s_tlast;
  logic [DW-1:0] m_axi4s_tdata;
  logic          m_axi4s_tvalid;
  logic          m_axi4s_tready = 1'b0;
  logic          status_busy;
  logic          status_overflow;
  logic [15:0]   status_frame_count;

  vin_to_axi4s dut (
    .aclk               (aclk),
    .areset             (areset),
    .ctl_enable         (ctl_enable),
    .ctl_clear          (ctl_clear),
    .in_vsync           (in_vsync),
    .in_hsync           (in_hsync),
    .in_de              (in_de),
    .in_data            (in_data),
    .m_axi4s_tuser      (m_axi4s_tuser),
    .m_axi4s_tlast      (m_axi4s_tlast),
    .m_axi4s_tdata      (m_axi4s_tdata),
    .m_axi4s_tvalid     (m_axi4s_tvalid),
    .m_axi4s_tready     (m_axi4s_tready),
    .status_busy        (status_busy),
    .status_overflow    (status_overflow),
    .status_frame_count (status_frame_count)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  int            m_mode = M_IDLE;
  int            m_count = 0;
  bit            m_sof = 1'b0;
  bit            m_stall = 1'b0;
  logic [DW+1:0] exp_q[$];
  int            beats = 0;
  logic          last_tlast = 1'b0;
  int            tready_mode = 1;
  bit            stalled = 1'b0;
  logic [DW+1:0] held_beat = '0;
  logic [DW+1:0] exp_beat;

  typedef struct {
    bit en;
    int en_line;
    bit en_mid;
    int nl;
    int ppl;
    int exp_beats;
    int exp_count;
    bit exp_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  always @(posedge aclk) begin
    #2;
    case (tready_mode)
      0:       m_axi4s_tready = 1'b0;
      1:       m_axi4s_tready = 1'b1;
      default: m_axi4s_tready = ($urandom_range(3) != 0);
    endcase
  end

  always @(negedge aclk) begin
    if (areset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", 64'(m_axi4s_tvalid), 64'd1);
        check("hold_beat", 64'({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}), 64'(held_beat));
      end
      if (m_axi4s_tvalid && m_axi4s_tready) begin
        beats++;
        last_tlast = m_axi4s_tlast;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat", 64'({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}), 64'(exp_beat));
        end
      end
      stalled   = m_axi4s_tvalid && !m_axi4s_tready;
      held_beat = {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata};
    end
  end

  task automatic set_enable(input bit v);
    ctl_enable = v;
    if (m_mode == M_IDLE && v) m_mode = M_WAIT;
  endtask

  task automatic model_vsync();
    case (m_mode)
      M_WAIT: begin
        m_mode = M_CAP;
        m_sof  = 1'b1;
      end
      M_CAP: begin
        m_count = (m_count + 1) % 65536;
        if (ctl_enable) m_sof = 1'b1;
        else m_mode = M_IDLE;
      end
      M_DROP: begin
        if (ctl_enable) begin
          m_mode = M_CAP;
          m_sof  = 1'b1;
        end else begin
          m_mode = M_IDLE;
        end
      end
      default: ;
    endcase
    if (m_mode == M_IDLE && ctl_enable) m_mode = M_WAIT;
  endtask

  task automatic drive_pixel(input bit last);
    logic [DW-1:0] d;
    d = DW'($urandom());
    in_de   = 1'b1;
    in_data = d;
    if (m_mode == M_CAP) begin
      if (m_stall && exp_q.size() >= DEPTH) begin
        m_mode = M_DROP;
      end else begin
        exp_q.push_back({m_sof, last, d});
        m_sof = 1'b0;
      end
    end
    tick();
  endtask

  task automatic vsync_pulse();
    in_vsync = 1'b1;
    model_vsync();
    tick();
    tick();
    in_vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic frame(input int nl, input int ppl, input int gap, input int en_line, input bit en_mid);
    vsync_pulse();
    for (int l = 0; l < nl; l++) begin
      if (l == en_line) set_enable(en_mid);
      for (int p = 0; p < ppl; p++) drive_pixel(p == ppl - 1);
      in_de    = 1'b0;
      in_hsync = 1'b1;
      tick();
      in_hsync = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic long_line(input int n, input int rdy_at, input int clr_at);
    vsync_pulse();
    for (int i = 0; i < n; i++) begin
      if (i == rdy_at) tready_mode = 1;
      ctl_clear = (i == clr_at);
      drive_pixel(i == n - 1);
    end
    ctl_clear = 1'b0;
    in_de = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (4) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int b0;
    vecs[0] = '{1'b1, -1, 1'b0, 2, 4, 8, 0, 1'b1};
    vecs[1] = '{1'b1, -1, 1'b0, 1, 3, 3, 1, 1'b1};
    vecs[2] = '{1'b1, -1, 1'b0, 3, 1, 3, 2, 1'b1};
    vecs[3] = '{1'b0, -1, 1'b0, 1, 2, 0, 3, 1'b0};
    vecs[4] = '{1'b0, -1, 1'b0, 1, 2, 0, 3, 1'b0};
    vecs[5] = '{1'b0,  1, 1'b1, 2, 4, 0, 3, 1'b0};
    vecs[6] = '{1'b1, -1, 1'b0, 1, 4, 4, 3, 1'b1};
    vecs[7] = '{1'b1,  1, 1'b0, 2, 3, 6, 4, 1'b1};
    vecs[8] = '{1'b0, -1, 1'b0, 1, 2, 0, 5, 1'b0};

    repeat (3) tick();
    check("rst_tvalid", 64'(m_axi4s_tvalid), 64'd0);
    check("rst_tuser", 64'(m_axi4s_tuser), 64'd0);
    check("rst_tlast", 64'(m_axi4s_tlast), 64'd0);
    check("rst_tdata", 64'(m_axi4s_tdata), 64'd0);
    check("rst_busy", 64'(status_busy), 64'd0);
    check("rst_overflow", 64'(status_overflow), 64'd0);
    check("rst_count", 64'(status_frame_count), 64'd0);
    areset = 1'b0;
    tick();

    tready_mode = 1;
    for (int i = 0; i < 9; i++) begin
      b0 = beats;
      set_enable(vecs[i].en);
      tick();
      tick();
      frame(vecs[i].nl, vecs[i].ppl, 2, vecs[i].en_line, vecs[i].en_mid);
      wait_drain();
      check($sformatf("vec%0d_beats", i), 64'(beats - b0), 64'(vecs[i].exp_beats));
      check($sformatf("vec%0d_count", i), 64'(status_frame_count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d_busy", i), 64'(status_busy), 64'(vecs[i].exp_busy));
    end

    // Overflow: stalled sink, one 80-pixel line.
    set_enable(1'b1);
    tick();
    tick();
    frame(1, 2, 2, -1, 1'b0);
    wait_drain();
    tready_mode = 0;
    m_stall = 1'b1;
    tick();
    tick();
    b0 = beats;
    frame(1, 80, 3, -1, 1'b0);
    tick();
    tick();
    check("ovf_set", 64'(status_overflow), 64'd1);
    check("ovf_drop_busy", 64'(status_busy), 64'd0);
    check("ovf_no_beats", 64'(beats - b0), 64'd0);
    tready_mode = 1;
    m_stall = 1'b0;
    wait_drain();
    check("ovf_beats", 64'(beats - b0), 64'd64);
    check("ovf_last_tlast", 64'(last_tlast), 64'd0);
    ctl_clear = 1'b1;
    tick();
    ctl_clear = 1'b0;
    tick();
    check("ovf_clear", 64'(status_overflow), 64'd0);
    b0 = beats;
    frame(1, 4, 2, -1, 1'b0);
    wait_drain();
    check("resync_beats", 64'(beats - b0), 64'd4);
    check("resync_count", 64'(status_frame_count), 64'(m_count));
    check("resync_busy", 64'(status_busy), 64'd1);

    // Full FIFO with simultaneous push and pop: no overflow.
    tready_mode = 0;
    tick();
    b0 = beats;
    long_line(70, 65, -1);
    wait_drain();
    check("fullpp_beats", 64'(beats - b0), 64'd70);
    check("fullpp_no_ovf", 64'(status_overflow), 64'd0);

    // Clear coinciding with overflow: set wins.
    tready_mode = 0;
    m_stall = 1'b1;
    tick();
    b0 = beats;
    long_line(70, -1, 65);
    check("clr_vs_ovf", 64'(status_overflow), 64'd1);
    tready_mode = 1;
    m_stall = 1'b0;
    wait_drain();
    check("clr_vs_ovf_beats", 64'(beats - b0), 64'd64);
    ctl_clear = 1'b1;
    tick();
    ctl_clear = 1'b0;
    tick();
    check("clr_after", 64'(status_overflow), 64'd0);

    // Reset in the middle of a line.
    tready_mode = 0;
    tick();
    vsync_pulse();
    for (int i = 0; i < 5; i++) drive_pixel(1'b0);
    check("pre_reset_valid", 64'(m_axi4s_tvalid), 64'd1);
    areset = 1'b1;
    tick();
    check("mid_rst_tvalid", 64'(m_axi4s_tvalid), 64'd0);
    check("mid_rst_busy", 64'(status_busy), 64'd0);
    check("mid_rst_ovf", 64'(status_overflow), 64'd0);
    check("mid_rst_count", 64'(status_frame_count), 64'd0);
    check("mid_rst_tdata", 64'(m_axi4s_tdata), 64'd0);
    areset = 1'b0;
    in_de = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_sof = 1'b0;
    m_mode = ctl_enable ? M_WAIT : M_IDLE;
    tick();
    tick();

    // Random frames against the frame-level model, random sink backpressure.
    tready_mode = 2;
    for (int f = 0; f < 25; f++) begin
      int nl;
      int ppl;
      int el;
      bit en;
      nl  = $urandom_range(3, 1);
      ppl = $urandom_range(16, 1);
      en  = ($urandom_range(3) != 0);
      el  = ($urandom_range(3) == 0) ? $urandom_range(nl - 1) : -1;
      set_enable(en);
      tick();
      tick();
      frame(nl, ppl, $urandom_range(4, 1), el, ~en);
      wait_drain();
      check($sformatf("rnd%0d_count", f), 64'(status_frame_count), 64'(m_count));
      check($sformatf("rnd%0d_busy", f), 64'(status_busy), 64'(m_mode == M_CAP));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
